mili_seq_driver: RTL and testbench
==================================

Name: mili_seq_driver

Overview:
- Sequencer for the 2-bit Gray-coded Mealy recogniser (clk, rst_n, en, a -> y).
- Loads a pattern word and clears the recogniser through its reset.
- Steps the pattern into the recogniser one bit per programmable period, LSB first.
- Captures the recogniser output y on every step into a result word and counts y hits; start/busy/done handshake toward the host.

Parameters:
- DATA_W, 8, maximum pattern length in bits (>=2).
- DIV_W, 8, width of the step-period divider.
- CNT_W, 4, width of len and hit_cnt; must hold DATA_W.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request, sampled in IDLE only.
- pattern  in  DATA_W  bits to feed, bit 0 first; latched on accepted start.
- len  in  CNT_W  number of steps; latched on accepted start.
- div  in  DIV_W  idle cycles between steps; latched on accepted start.
- fsm_rst_n  out  1  registered reset to recogniser; low only in LOAD.
- fsm_en  out  1  step strobe to recogniser; high only in STEP.
- fsm_a  out  1  data bit to recogniser = shift[0] while busy, 0 in IDLE/DONE.
- fsm_y  in  1  recogniser Mealy output; combinational from its fsm_a and state.
- busy  out  1  high LOAD through STEP/WAIT, low in IDLE and DONE.
- done  out  1  one-cycle pulse in DONE.
- result  out  DATA_W  result[i] = fsm_y sampled at step i; upper bits 0.
- hit_cnt  out  CNT_W  number of steps with fsm_y=1.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, fsm_en=0, fsm_a=0, fsm_rst_n=1, result=0, hit_cnt=0, internal shift/idx/prescaler=0.
- Asynchronous reset mid-run aborts immediately; no done pulse.
- States: IDLE, LOAD, WAIT, STEP, DONE.
- IDLE: if start=1, latch pattern/len/div, go to LOAD; else hold. result/hit_cnt keep the last run's values.
- LOAD (1 cycle):
  - fsm_rst_n=0; clear result, hit_cnt, idx.
  - Clamp len>DATA_W to DATA_W.
  - Next state: len==0 -> DONE; else div==0 -> STEP; else WAIT with prescaler=div.
- WAIT: decrement prescaler; after exactly div cycles go to STEP.
- STEP (1 cycle):
  - fsm_en=1; fsm_a=shift[0]; result[idx]<=fsm_y; hit_cnt+=fsm_y; shift>>=1; idx+=1.
  - If idx==len-1: go to DONE.
  - Else: go to WAIT (prescaler reloaded to div), or straight to STEP if div==0.
- Step period is div+1 cycles.
- DONE (1 cycle): done=1, then go to IDLE.
- start while busy or in DONE is ignored; no queueing.
- Latency, len=N, div=D: start sampled at cycle 0 -> LOAD at cycle 1 -> N steps, (N-1)*D WAIT cycles between steps plus D before the first -> done at cycle 2+N+N*D.
- fsm_y is sampled in the same cycle fsm_en is high, i.e. before the recogniser's state update (Mealy semantics).
- hit_cnt cannot overflow because CNT_W holds DATA_W.

Optional Feature:
- MILI_SEQ_ABORT_EN defined: adds input abort (1 bit).
  - abort=1 in LOAD, WAIT or STEP forces DONE next cycle.
  - Any in-cycle STEP capture still completes; done pulses.
  - Adds output aborted (1 bit): set with that done, cleared on next accepted start.
- Undefined: no abort port, no aborted port; runs always complete len steps.

Decomposition:
- Package mili_seq_pkg holds the state enum encoding (IDLE, LOAD, WAIT, STEP, DONE) and default widths.
- One natural sub-module: mili_seq_prescaler, a loadable down-counter with a zero flag, used for WAIT timing.
- Everything else stays in the top module.

Test Plan:
- pattern=8'b0000_0110, len=3, div=0 -> fsm_a sequence 0,1,1; result=8'b0000_0110; hit_cnt=2; done at cycle 5 after start.
- pattern=8'hFF, len=8, div=2 -> recogniser stays S0; result=0; hit_cnt=0; fsm_en pulses spaced 3 cycles; done at cycle 2+8+16=26.
- pattern=8'h00, len=4, div=1 -> recogniser walks S0->S1->S2->S3->S0; result=0; hit_cnt=0; fsm_rst_n low exactly in cycle 1.
- len=0 -> LOAD then DONE; no fsm_en pulse; result=0; done at cycle 2. len=15 -> clamped to 8 steps.
- start held high through a whole run, plus rst_n pulsed low mid-WAIT -> no second run while busy; reset returns all outputs to reset values immediately; no done pulse.
- With MILI_SEQ_ABORT_EN: abort during the 2nd WAIT of a len=8 run -> done next cycle; aborted=1; hit_cnt reflects only the completed steps.

Source files
------------

// File: rtl/mili_seq_pkg.sv
// rtl/mili_seq_pkg.sv - shared state encoding and default widths for the sequence driver
package mili_seq_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DIV_W  = 8;
    localparam int DEF_CNT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_STEP = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/mili_seq_prescaler.sv
// rtl/mili_seq_prescaler.sv - loadable down-counter with zero flag for step spacing
module mili_seq_prescaler #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mili_seq_driver.sv
// rtl/mili_seq_driver.sv - steps a pattern into the Mealy recogniser and captures y; MILI_SEQ_ABORT_EN adds abort/aborted
module mili_seq_driver
    import mili_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DIV_W  = DEF_DIV_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] pattern,
    input  logic [CNT_W-1:0]  len,
    input  logic [DIV_W-1:0]  div,
`ifdef MILI_SEQ_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic              fsm_rst_n,
    output logic              fsm_en,
    output logic              fsm_a,
    input  logic              fsm_y,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [CNT_W-1:0]  hit_cnt
);

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(DATA_W);

    state_t            state, state_n;
    logic [DATA_W-1:0] shift;
    logic [CNT_W-1:0]  len_q;
    logic [DIV_W-1:0]  div_q;
    logic [CNT_W-1:0]  idx;
    logic              pre_load, pre_dec, pre_zero;
`ifdef MILI_SEQ_ABORT_EN
    logic              abort_hit;
`endif

    // Loaded with div-1 so the zero flag marks the last of exactly div WAIT cycles.
    mili_seq_prescaler #(.W(DIV_W)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pre_load),
        .dec   (pre_dec),
        .value (div_q - 1'b1),
        .zero  (pre_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        pre_load = 1'b0;
        pre_dec  = 1'b0;
`ifdef MILI_SEQ_ABORT_EN
        abort_hit = 1'b0;
`endif
        case (state)
            ST_IDLE: if (start) state_n = ST_LOAD;
            ST_LOAD: begin
                if (len_q == '0) begin
                    state_n = ST_DONE;
                end else if (div_q == '0) begin
                    state_n = ST_STEP;
                end else begin
                    state_n  = ST_WAIT;
                    pre_load = 1'b1;
                end
            end
            ST_WAIT: begin
                pre_dec = 1'b1;
                if (pre_zero) state_n = ST_STEP;
            end
            ST_STEP: begin
                if (idx == len_q - 1'b1) begin
                    state_n = ST_DONE;
                end else if (div_q == '0) begin
                    state_n = ST_STEP;
                end else begin
                    state_n  = ST_WAIT;
                    pre_load = 1'b1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
`ifdef MILI_SEQ_ABORT_EN
        if (abort && (state == ST_LOAD || state == ST_WAIT || state == ST_STEP)) begin
            state_n   = ST_DONE;
            pre_load  = 1'b0;
            abort_hit = 1'b1;
        end
`endif
    end

    assign busy   = (state == ST_LOAD) || (state == ST_WAIT) || (state == ST_STEP);
    assign done   = (state == ST_DONE);
    assign fsm_en = (state == ST_STEP);
    assign fsm_a  = busy & shift[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift     <= '0;
            len_q     <= '0;
            div_q     <= '0;
            idx       <= '0;
            result    <= '0;
            hit_cnt   <= '0;
            fsm_rst_n <= 1'b1;
        end else begin
            fsm_rst_n <= (state_n != ST_LOAD);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shift <= pattern;
                        len_q <= len;
                        div_q <= div;
                    end
                end
                ST_LOAD: begin
                    result  <= '0;
                    hit_cnt <= '0;
                    idx     <= '0;
                    if (len_q > MAX_LEN) len_q <= MAX_LEN;
                end
                // Mealy capture: y is read while fsm_en is high, before the recogniser moves.
                ST_STEP: begin
                    result  <= result | (DATA_W'(fsm_y) << idx);
                    hit_cnt <= hit_cnt + CNT_W'(fsm_y);
                    shift   <= shift >> 1;
                    idx     <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MILI_SEQ_ABORT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aborted <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            aborted <= 1'b0;
        end else if (abort_hit) begin
            aborted <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mili_seq_driver.sv
// tb/tb_mili_seq_driver.sv - self-checking bench for mili_seq_driver with a behavioural recogniser
module tb_mili_seq_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] len = '0;
    logic [7:0] div = '0;
    logic       fsm_rst_n, fsm_en, fsm_a, fsm_y, busy, done;
    logic [7:0] result;
    logic [3:0] hit_cnt;
`ifdef MILI_SEQ_ABORT_EN
    logic       abort = 1'b0;
    logic       aborted;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mili_seq_driver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pattern   (pattern),
        .len       (len),
        .div       (div),
`ifdef MILI_SEQ_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .fsm_rst_n (fsm_rst_n),
        .fsm_en    (fsm_en),
        .fsm_a     (fsm_a),
        .fsm_y     (fsm_y),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .hit_cnt   (hit_cnt)
    );

    // Recogniser stand-in: a=0 walks the Gray ring S0..S3, a=1 holds; y=1 when a=1 away from S0.
    logic [1:0] rstate;
    always @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) rstate <= 2'b00;
        else if (fsm_en && !fsm_a)
            case (rstate)
                2'b00:   rstate <= 2'b01;
                2'b01:   rstate <= 2'b11;
                2'b11:   rstate <= 2'b10;
                default: rstate <= 2'b00;
            endcase
    end
    assign fsm_y = fsm_a & (rstate != 2'b00);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [7:0] p, input int n,
                                  output logic [7:0] res, output int hits);
        int pos = 0;
        res  = '0;
        hits = 0;
        for (int i = 0; i < n; i++) begin
            if (p[i]) begin
                if (pos != 0) begin
                    res[i] = 1'b1;
                    hits++;
                end
            end else begin
                pos = (pos + 1) % 4;
            end
        end
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_en"},    fsm_en, 0);
        chk({tag, "_a"},     fsm_a, 0);
        chk({tag, "_frst"},  fsm_rst_n, 1);
        chk({tag, "_res"},   result, 0);
        chk({tag, "_hits"},  hit_cnt, 0);
    endtask

    task automatic run(input logic [7:0] p, input logic [3:0] l, input int d, input bit hold);
        int n, exp_done, hits, k;
        logic [7:0] res;
        bit exp_en;
        n = (l > 4'd8) ? 8 : int'(l);
        exp_done = 2 + n + n * d;
        model(p, n, res, hits);
        @(negedge clk);
        pattern = p; len = l; div = 8'(d); start = 1'b1;
        for (int j = 1; j <= exp_done + 1; j++) begin
            @(posedge clk); #1;
            if (!hold || j >= exp_done) start = 1'b0;
            pattern = 8'($urandom); len = 4'($urandom); div = 8'($urandom);
            exp_en = (j >= 2) && (j < exp_done) && ((j - 1) % (d + 1) == 0);
            chk($sformatf("busy_c%0d", j), busy, j < exp_done);
            chk($sformatf("done_c%0d", j), done, j == exp_done);
            chk($sformatf("en_c%0d", j), fsm_en, exp_en);
            chk($sformatf("frst_c%0d", j), fsm_rst_n, j != 1);
            if (exp_en) begin
                k = (j - 1) / (d + 1) - 1;
                chk($sformatf("a_step%0d", k), fsm_a, p[k]);
            end
            if (j >= exp_done) chk($sformatf("a_idle_c%0d", j), fsm_a, 0);
        end
        chk("result", result, res);
        chk("hit_cnt", hit_cnt, hits);
`ifdef MILI_SEQ_ABORT_EN
        chk("aborted_clr", aborted, 0);
`endif
    endtask

    initial begin
        #12;
        chk_reset_vals("rst");
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("idle");

        run(8'b0000_0110, 4'd3, 0, 1'b0);
        run(8'hFF, 4'd8, 2, 1'b0);
        run(8'h00, 4'd4, 1, 1'b0);
        run(8'h5A, 4'd0, 3, 1'b0);
        run(8'b1011_0010, 4'd15, 0, 1'b0);
        run(8'b0110_1101, 4'd6, 1, 1'b1);
        for (int r = 0; r < 10; r++)
            run(8'($urandom), 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), r[0]);

        // Asynchronous reset in the middle of a WAIT
        @(negedge clk);
        pattern = 8'hB6; len = 4'd8; div = 8'd3; start = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk); start = 1'b0; rst_n = 1'b1;
        for (int j = 0; j < 40; j++) begin
            @(posedge clk); #1;
            chk($sformatf("postrst_done%0d", j), done, 0);
            chk($sformatf("postrst_busy%0d", j), busy, 0);
        end

`ifdef MILI_SEQ_ABORT_EN
        // Abort during the second WAIT of a len=8, div=2 run: one step done, DONE next
        @(negedge clk);
        pattern = 8'hA5; len = 4'd8; div = 8'd2; start = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (j == 5) abort = 1'b1;
            if (j == 6) begin
                abort = 1'b0;
                chk("ab_done", done, 1);
                chk("ab_flag", aborted, 1);
                chk("ab_hits", hit_cnt, 0);
                chk("ab_res", result, 0);
            end
            if (j == 7) chk("ab_busy", busy, 0);
        end
        run(8'b0000_0110, 4'd3, 0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
